// File: rtl/pulse_gap_pacer_pkg.sv
// pulse_gap_pacer shared types and helpers.
// State encodings, gap counter sizing and MIN_GAP legality.
package pulse_gap_pacer_pkg;

   typedef enum logic [1:0] {
      IDLE = 2'd0,
      EMIT = 2'd1,
      GAP  = 2'd2
   } state_t;

   localparam int DEF_CNT_W   = 4;
   localparam int DEF_MIN_GAP = 4;

   // MIN_GAP-2 is the largest value loaded, so $clog2(MIN_GAP) bits suffice.
   function automatic int gap_w(input int min_gap);
      return (min_gap < 2) ? 1 : $clog2(min_gap);
   endfunction

   // A one-cycle EMIT plus at least one GAP cycle needs MIN_GAP >= 2.
   function automatic bit min_gap_ok(input int min_gap);
      return min_gap >= 2;
   endfunction

endpackage

// File: rtl/sat_updown_cnt.sv
// Saturating up/down counter with synchronous clear.
// ovf strobes when an increment is refused at full scale.
module sat_updown_cnt #(
   parameter int CNT_W = 4
) (
   input  logic             src_clk,
   input  logic             src_rstn,
   input  logic             clr,
   input  logic             inc,
   input  logic             dec,
   output logic [CNT_W-1:0] cnt,
   output logic             ovf
);

   logic full;
   logic empty;
   logic up;
   logic down;

   assign full  = &cnt;
   assign empty = ~|cnt;
   assign up    = inc & ~dec;
   assign down  = dec & ~inc;

   // Clear wins, so a clear also suppresses the drop strobe.
   assign ovf = up & full & ~clr;

   // Count register: simultaneous inc and dec cancel out.
   always_ff @(posedge src_clk or negedge src_rstn) begin
      if (!src_rstn) begin
         cnt <= '0;
      end else if (clr) begin
         cnt <= '0;
      end else if (up && !full) begin
         cnt <= cnt + 1'b1;
      end else if (down && !empty) begin
         cnt <= cnt - 1'b1;
      end
   end

endmodule

// File: rtl/pulse_gap_pacer.sv
// Paces queued event pulses at least MIN_GAP src_clk cycles apart.
// Optional ack handshake in GAP: define PULSE_GAP_PACER_ACK_EN.
module pulse_gap_pacer
   import pulse_gap_pacer_pkg::*;
#(
   parameter int CNT_W   = DEF_CNT_W,
   parameter int MIN_GAP = DEF_MIN_GAP
) (
   input  logic             src_clk,
   input  logic             src_rstn,
   input  logic             src_clr,
   input  logic             evt_i,
`ifdef PULSE_GAP_PACER_ACK_EN
   input  logic             ack_i,
`endif
   input  logic             ovf_clr,
   output logic             pulse_o,
   output logic [CNT_W-1:0] pending_o,
   output logic             busy_o,
   output logic             ovf_o
);

   localparam int GW = gap_w(MIN_GAP);
   localparam logic [GW-1:0] GAP_LOAD = GW'(MIN_GAP - 2);

   if (!min_gap_ok(MIN_GAP)) begin : g_min_gap_chk
      $error("pulse_gap_pacer: MIN_GAP must be at least 2");
   end

   state_t        state_q;
   state_t        state_d;
   logic [GW-1:0] gap_q;
   logic [GW-1:0] gap_d;
   logic          dec;
   logic          drop;
   logic          pend_nz;
   logic          gap_exit_ok;

   assign dec     = (state_q == EMIT);
   assign pend_nz = |pending_o;

   sat_updown_cnt #(
      .CNT_W (CNT_W)
   ) u_pend (
      .src_clk  (src_clk),
      .src_rstn (src_rstn),
      .clr      (src_clr),
      .inc      (evt_i),
      .dec      (dec),
      .cnt      (pending_o),
      .ovf      (drop)
   );

`ifdef PULSE_GAP_PACER_ACK_EN
   logic ack_seen_q;

   // Remember an ack that arrives before the gap timer expires.
   always_ff @(posedge src_clk or negedge src_rstn) begin
      if (!src_rstn) begin
         ack_seen_q <= 1'b0;
      end else if (src_clr) begin
         ack_seen_q <= 1'b0;
      end else if (state_q == EMIT) begin
         ack_seen_q <= 1'b0;
      end else if (state_q == GAP && ack_i) begin
         ack_seen_q <= 1'b1;
      end
   end

   assign gap_exit_ok = ack_seen_q | ack_i;
`else
   assign gap_exit_ok = 1'b1;
`endif

   // State and gap timer registers.
   always_ff @(posedge src_clk or negedge src_rstn) begin
      if (!src_rstn) begin
         state_q <= IDLE;
         gap_q   <= '0;
      end else begin
         state_q <= state_d;
         gap_q   <= gap_d;
      end
   end

   // Next state: EMIT is one cycle, GAP holds MIN_GAP-1 cycles.
   always_comb begin
      state_d = state_q;
      gap_d   = gap_q;
      unique case (state_q)
         IDLE: begin
            if (pend_nz) begin
               state_d = EMIT;
            end
         end
         EMIT: begin
            gap_d   = GAP_LOAD;
            state_d = GAP;
         end
         GAP: begin
            if (gap_q != '0) begin
               gap_d = gap_q - 1'b1;
            end else if (gap_exit_ok) begin
               state_d = pend_nz ? EMIT : IDLE;
            end
         end
         default: begin
            state_d = IDLE;
            gap_d   = '0;
         end
      endcase
      if (src_clr) begin
         state_d = IDLE;
         gap_d   = '0;
      end
   end

   // Sticky drop flag; a drop beats a same-cycle ovf_clr.
   always_ff @(posedge src_clk or negedge src_rstn) begin
      if (!src_rstn) begin
         ovf_o <= 1'b0;
      end else if (src_clr) begin
         ovf_o <= 1'b0;
      end else if (drop) begin
         ovf_o <= 1'b1;
      end else if (ovf_clr) begin
         ovf_o <= 1'b0;
      end
   end

   assign pulse_o = (state_q == EMIT);
   assign busy_o  = (state_q != IDLE) | pend_nz;

endmodule
